hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core. It sits in the decode stage, directly upstream of the operand-forwarding unit.

It resolves the hazards forwarding cannot handle:
- load-use interlock (one bubble)
- taken-branch/jump squash (two younger instructions)
- whole-pipe freeze while data memory is busy

It drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, the PC enable and redirect, a sticky memory-timeout error, and two saturating performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_sat_counter.sv | 32 +++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the decode-stage hazard controller:
// FSM states, the x0 register index and the pipeline bubble encoding.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hz_state_t;

    localparam logic [4:0] X0 = 5'd0;

    // Control bundle carried by ID/EX and MEM/WB; a bubble writes nothing and targets x0.
    typedef struct packed {
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic [4:0] rd;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t BUBBLE_CTRL = '{reg_we: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, rd: X0};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters;
// sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use interlock, taken-branch squash and
// whole-pipe freeze on data-memory busy, with a sticky memory-timeout error.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [4:0]       e_rd,
    input  logic             e_memread,
    input  logic             e_brtaken,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_stall,
    output logic             de_flush,
    output logic             em_stall,
    output logic             mw_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t       state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic [WC_W-1:0] wait_nxt;
    logic            lu;
    logic            freeze;
    logic            run_eval;

    assign lu = e_memread && (e_rd != X0) &&
                ((d_use_rs1 && (d_rs1 == e_rd)) || (d_use_rs2 && (d_rs2 == e_rd)));

    assign wait_nxt = wait_cnt_q + WC_W'(1);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        freeze      = 1'b0;
        run_eval    = 1'b0;
        pc_stall    = 1'b0;
        pc_redirect = 1'b0;
        fd_stall    = 1'b0;
        fd_flush    = 1'b0;
        de_stall    = 1'b0;
        de_flush    = 1'b0;
        em_stall    = 1'b0;
        mw_flush    = 1'b0;

        if (rst) begin
            // Fill the pipe with bubbles while reset is held.
            fd_flush = 1'b1;
            de_flush = 1'b1;
            mw_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: run_eval = 1'b1;
                WAIT: begin
                    if (mem_busy) begin
                        freeze     = 1'b1;
                        wait_cnt_d = wait_nxt;
                        if (wait_nxt >= WC_W'(MEM_TIMEOUT)) begin
                            state_d   = ERR;
                            mem_err_d = 1'b1;
                        end
                    end else begin
                        // Memory released: this cycle is already a normal RUN cycle.
                        state_d  = RUN;
                        run_eval = 1'b1;
                    end
                end
                ERR:     freeze = 1'b1;
                default: state_d = RUN;
            endcase

            if (run_eval) begin
                if (mem_busy) begin
                    freeze     = 1'b1;
                    state_d    = WAIT;
                    wait_cnt_d = WC_W'(1);
                    if (MEM_TIMEOUT <= 1) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end
                end else if (e_brtaken) begin
                    // The load-use victim is among the squashed slots, so lu is moot.
                    pc_redirect = 1'b1;
                    fd_flush    = 1'b1;
                    de_flush    = 1'b1;
                end else if (lu) begin
                    pc_stall = 1'b1;
                    fd_stall = 1'b1;
                    de_flush = 1'b1;
                end
            end

            if (freeze) begin
                pc_stall = 1'b1;
                fd_stall = 1'b1;
                de_stall = 1'b1;
                em_stall = 1'b1;
                mw_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_stall),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_redirect),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and narrow counters
// so timeout and saturation corners are reachable in a few cycles.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 2;

    // Output vector order: pc_stall, pc_redirect, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_flush
    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_RST    = 8'b0001_0101;
    localparam logic [7:0] O_LU     = 8'b1010_0100;
    localparam logic [7:0] O_BR     = 8'b0101_0100;
    localparam logic [7:0] O_FREEZE = 8'b1010_1011;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       d_rs1, d_rs2, e_rd;
    logic             d_use_rs1, d_use_rs2, e_memread, e_brtaken, mem_busy;
    logic             pc_stall, pc_redirect, fd_stall, fd_flush;
    logic             de_stall, de_flush, em_stall, mw_flush, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0]       outs;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .d_rs1       (d_rs1),
        .d_rs2       (d_rs2),
        .d_use_rs1   (d_use_rs1),
        .d_use_rs2   (d_use_rs2),
        .e_rd        (e_rd),
        .e_memread   (e_memread),
        .e_brtaken   (e_brtaken),
        .mem_busy    (mem_busy),
        .pc_stall    (pc_stall),
        .pc_redirect (pc_redirect),
        .fd_stall    (fd_stall),
        .fd_flush    (fd_flush),
        .de_stall    (de_stall),
        .de_flush    (de_flush),
        .em_stall    (em_stall),
        .mw_flush    (mw_flush),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    assign outs = {pc_stall, pc_redirect, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        d_rs1 = 5'd0; d_rs2 = 5'd0; e_rd = 5'd0;
        d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
        e_memread = 1'b0; e_brtaken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_lu();
        e_memread = 1'b1; e_rd = 5'd5; d_use_rs1 = 1'b1; d_rs1 = 5'd5;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        clr_in();
        rst = 1'b1;
        #1 check("rst_outs", 32'(outs), 32'(O_RST));
        @(negedge clk);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_flush_cnt", 32'(flush_cnt), 0);
        check("rst_mem_err", 32'(mem_err), 0);
        rst = 1'b0;
        #1 check("idle_outs", 32'(outs), 32'(O_NONE));

        // Load-use: one bubble, then clear
        set_lu();
        #1 check("lu_outs", 32'(outs), 32'(O_LU));
        @(negedge clk);
        check("lu_stall_cnt", 32'(stall_cnt), 1);
        e_memread = 1'b0;
        #1 check("lu_after_outs", 32'(outs), 32'(O_NONE));

        // x0 destination and unused source never interlock
        clr_in();
        e_memread = 1'b1; e_rd = 5'd0; d_rs1 = 5'd0; d_use_rs1 = 1'b1;
        #1 check("x0_outs", 32'(outs), 32'(O_NONE));
        e_rd = 5'd7; d_use_rs1 = 1'b0; d_rs2 = 5'd7; d_use_rs2 = 1'b0;
        #1 check("unused_rs2_outs", 32'(outs), 32'(O_NONE));
        d_use_rs2 = 1'b1;
        #1 check("rs2_lu_outs", 32'(outs), 32'(O_LU));

        // Branch beats load-use
        do_reset();
        set_lu();
        e_brtaken = 1'b1;
        #1 check("br_lu_outs", 32'(outs), 32'(O_BR));
        check("br_flush_cnt0", 32'(flush_cnt), 0);
        @(negedge clk);
        check("br_flush_cnt1", 32'(flush_cnt), 1);
        check("br_stall_cnt", 32'(stall_cnt), 0);

        // Memory wait with a held branch: 3 frozen cycles, redirect on the 4th
        do_reset();
        mem_busy = 1'b1; e_brtaken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("wait_freeze%0d", i), 32'(outs), 32'(O_FREEZE));
            @(negedge clk);
        end
        mem_busy = 1'b0;
        #1 check("wait_release_outs", 32'(outs), 32'(O_BR));
        check("wait_stall_cnt", 32'(stall_cnt), 3);
        check("wait_mem_err", 32'(mem_err), 0);
        @(negedge clk);
        check("wait_flush_cnt", 32'(flush_cnt), 1);
        clr_in();
        #1 check("wait_done_outs", 32'(outs), 32'(O_NONE));

        // Timeout: mem_err on the 4th busy edge, freeze is permanent until reset
        do_reset();
        mem_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1 check($sformatf("to_freeze%0d", i), 32'(outs), 32'(O_FREEZE));
            @(negedge clk);
            check($sformatf("to_mem_err%0d", i), 32'(mem_err), (i == 4) ? 1 : 0);
        end
        mem_busy = 1'b0;
        #1 check("err_freeze_a", 32'(outs), 32'(O_FREEZE));
        @(negedge clk);
        check("err_freeze_b", 32'(outs), 32'(O_FREEZE));
        check("err_sticky", 32'(mem_err), 1);
        rst = 1'b1;
        #1 check("err_rst_outs", 32'(outs), 32'(O_RST));
        @(negedge clk);
        check("err_rst_mem_err", 32'(mem_err), 0);
        check("err_rst_stall_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;
        #1 check("err_rst_run_outs", 32'(outs), 32'(O_NONE));

        // Saturation of both 2-bit counters
        do_reset();
        set_lu();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("sat_stall%0d", i), 32'(stall_cnt), (i < 3) ? i : 3);
        end
        clr_in();
        e_brtaken = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("sat_flush%0d", i), 32'(flush_cnt), (i < 3) ? i : 3);
        end
        check("sat_stall_hold", 32'(stall_cnt), 3);
        clr_in();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
